// File: rtl/death_anim_reader.sv
// Death-animation sprite sequencer: frame/tick FSM, ROM address generation and a
// three-register pixel pipeline (address, ROM, output) with colour-key transparency.
module death_anim_reader #(
    parameter int unsigned SPR_W       = 32,
    parameter int unsigned SPR_H       = 32,
    parameter int unsigned N_FRAMES    = 5,
    parameter int unsigned FRAME_TICKS = 6,
    parameter logic [23:0] KEY_COLOR   = 24'hfffed2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic        frame_tick,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  SpriteX,
    input  logic [9:0]  SpriteY,
    output logic [18:0] read_address,
    output logic [2:0]  frame_sel,
    input  logic [23:0] rom_data,
    output logic        pix_valid,
    output logic [23:0] pix_color,
    output logic        busy,
    output logic        done
);

    localparam int unsigned ADDR_W  = 19;
    localparam int unsigned FRAME_W = 3;
    localparam int unsigned TICK_W  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int unsigned COORD_W = 11;

    typedef enum logic {IDLE, PLAY} state_e;

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [TICK_W-1:0]    tick_q,  tick_d;
    logic                 done_q,  done_d;

    logic [COORD_W-1:0]   dx, dy;
    logic                 hit;
    logic [ADDR_W-1:0]    addr_d, addr_q;
    logic                 hit1_q, hit2_q;
    logic                 busy1_q, busy2_q;
    logic                 pix_valid_d, pix_valid_q;
    logic [23:0]          pix_color_d, pix_color_q;

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            frame_q <= '0;
            tick_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    // Next state: start always wins over a coincident frame_tick
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        tick_d  = tick_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PLAY;
                    frame_d = '0;
                    tick_d  = '0;
                end
            end
            PLAY: begin
                if (start) begin
                    frame_d = '0;
                    tick_d  = '0;
                end else if (frame_tick) begin
                    if (tick_q < TICK_W'(FRAME_TICKS - 1)) begin
                        tick_d = tick_q + TICK_W'(1);
                    end else begin
                        tick_d = '0;
                        if (frame_q == FRAME_W'(N_FRAMES - 1)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            frame_d = frame_q + FRAME_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = (state_q == PLAY);
        done      = done_q;
        frame_sel = frame_q;
    end

    // Sprite-relative offset; a set sign bit means the scan is left of / above the sprite
    always_comb begin
        dx     = COORD_W'(DrawX) - COORD_W'(SpriteX);
        dy     = COORD_W'(DrawY) - COORD_W'(SpriteY);
        hit    = !dx[COORD_W-1] && (dx[9:0] < 10'(SPR_W)) &&
                 !dy[COORD_W-1] && (dy[9:0] < 10'(SPR_H));
        addr_d = hit ? (ADDR_W'(dy[9:0]) * ADDR_W'(SPR_W) + ADDR_W'(dx[9:0])) : '0;
    end

    always_comb begin
        pix_valid_d = hit2_q && busy2_q && (rom_data != KEY_COLOR);
        pix_color_d = pix_valid_d ? rom_data : '0;
    end

    // Pixel pipeline: hit/busy follow the address through the ROM's one-cycle latency
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            addr_q      <= '0;
            hit1_q      <= 1'b0;
            hit2_q      <= 1'b0;
            busy1_q     <= 1'b0;
            busy2_q     <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_color_q <= '0;
        end else begin
            addr_q      <= addr_d;
            hit1_q      <= hit;
            hit2_q      <= hit1_q;
            busy1_q     <= busy;
            busy2_q     <= busy1_q;
            pix_valid_q <= pix_valid_d;
            pix_color_q <= pix_color_d;
        end
    end

    assign read_address = addr_q;
    assign pix_valid    = pix_valid_q;
    assign pix_color    = pix_color_q;

endmodule

// File: tb/tb_death_anim_reader.sv
// Directed bench for death_anim_reader with a one-cycle registered ROM model.
module tb_death_anim_reader;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        start;
    logic        frame_tick;
    logic [9:0]  DrawX, DrawY, SpriteX, SpriteY;
    logic [18:0] read_address;
    logic [2:0]  frame_sel;
    logic [23:0] rom_data = 24'h0;
    logic        pix_valid;
    logic [23:0] pix_color;
    logic        busy;
    logic        done;

    logic [23:0] rom_word;
    int checks   = 0;
    int failures = 0;

    death_anim_reader dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .start        (start),
        .frame_tick   (frame_tick),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .SpriteX      (SpriteX),
        .SpriteY      (SpriteY),
        .read_address (read_address),
        .frame_sel    (frame_sel),
        .rom_data     (rom_data),
        .pix_valid    (pix_valid),
        .pix_color    (pix_color),
        .busy         (busy),
        .done         (done)
    );

    always #5 Clk = ~Clk;

    // ROM model: address 67 returns the programmable word, others a fixed pattern
    always @(posedge Clk) begin
        rom_data <= (read_address == 19'd67) ? rom_word : (24'h123456 ^ 24'(read_address));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_frame", 32'(frame_sel), 32'd0);
    endtask

    // Ticks numbered from the most recent (re)start; tick 30 ends the animation
    task automatic run_ticks(input int first, input int last);
        for (int t = first; t <= last; t++) begin
            frame_tick = 1'b1;
            step(1);
            frame_tick = 1'b0;
            if (t < 30) begin
                check($sformatf("frame_t%0d", t), 32'(frame_sel), 32'(t / 6));
                check($sformatf("busy_t%0d", t), 32'(busy), 32'd1);
                check($sformatf("nodone_t%0d", t), 32'(done), 32'd0);
            end else begin
                check("done_pulse", 32'(done), 32'd1);
                check("busy_end", 32'(busy), 32'd0);
                check("frame_end", 32'(frame_sel), 32'd4);
                step(1);
                check("done_clear", 32'(done), 32'd0);
                check("frame_hold", 32'(frame_sel), 32'd4);
                check("busy_idle", 32'(busy), 32'd0);
            end
            step(1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"},  32'(read_address), 32'd0);
        check({tag, "_frame"}, 32'(frame_sel), 32'd0);
        check({tag, "_pv"},    32'(pix_valid), 32'd0);
        check({tag, "_pc"},    32'(pix_color), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
    endtask

    int sx [8] = '{103, 100, 131,  99, 132, 103, 103, 110};
    int sy [8] = '{ 52,  50,  81,  52,  52,  49,  82,  60};
    int sa [8] = '{ 67,   0, 1023,  0,   0,   0,   0, 330};

    initial begin
        Reset_n    = 1'b0;
        start      = 1'b0;
        frame_tick = 1'b0;
        DrawX      = 10'd0;
        DrawY      = 10'd0;
        SpriteX    = 10'd100;
        SpriteY    = 10'd50;
        rom_word   = 24'hd54014;
        #3;
        check_all_zero("reset");
        step(2);
        Reset_n = 1'b1;
        step(1);

        // Idle: address still generated, sprite hidden
        for (int i = 0; i < 8; i++) begin
            DrawX = 10'(sx[i]);
            DrawY = 10'(sy[i]);
            step(1);
            check($sformatf("idle_addr%0d", i), 32'(read_address), 32'(sa[i]));
            check($sformatf("idle_busy%0d", i), 32'(busy), 32'd0);
        end
        DrawX = 10'd103;
        DrawY = 10'd52;
        step(4);
        check("idle_hidden", 32'(pix_valid), 32'd0);

        // Opaque pixel through the three-register pipeline
        DrawX = 10'd0;
        DrawY = 10'd0;
        do_start();
        step(4);
        DrawX = 10'd103;
        DrawY = 10'd52;
        step(1);
        check("play_addr", 32'(read_address), 32'd67);
        step(1);
        check("lat_early", 32'(pix_valid), 32'd0);
        step(1);
        check("lat_pv", 32'(pix_valid), 32'd1);
        check("lat_pc", 32'(pix_color), 32'hd54014);

        // Key colour is transparent
        rom_word = 24'hfffed2;
        step(3);
        check("key_pv", 32'(pix_valid), 32'd0);
        check("key_pc", 32'(pix_color), 32'd0);
        rom_word = 24'hd54014;

        // Edge misses either side
        DrawX = 10'd99;
        step(1);
        check("miss_l_addr", 32'(read_address), 32'd0);
        step(2);
        check("miss_l_pv", 32'(pix_valid), 32'd0);
        DrawX = 10'd132;
        step(1);
        check("miss_r_addr", 32'(read_address), 32'd0);
        step(2);
        check("miss_r_pv", 32'(pix_valid), 32'd0);
        DrawX = 10'd0;

        // Full animation from the earlier start
        run_ticks(1, 30);
        DrawX = 10'd103;
        step(4);
        check("after_done_hidden", 32'(pix_valid), 32'd0);
        DrawX = 10'd0;

        // Restart mid-animation, then full replay
        do_start();
        run_ticks(1, 14);
        check("pre_restart_frame", 32'(frame_sel), 32'd2);
        do_start();
        run_ticks(1, 30);

        // Start coincident with frame_tick: restart with no advance
        do_start();
        run_ticks(1, 5);
        start      = 1'b1;
        frame_tick = 1'b1;
        step(1);
        start      = 1'b0;
        frame_tick = 1'b0;
        check("coinc_frame", 32'(frame_sel), 32'd0);
        check("coinc_busy", 32'(busy), 32'd1);
        step(1);
        run_ticks(1, 30);

        // Asynchronous reset in frame 3 while a pixel is visible
        DrawX = 10'd103;
        DrawY = 10'd52;
        do_start();
        run_ticks(1, 20);
        check("pre_rst_frame", 32'(frame_sel), 32'd3);
        check("pre_rst_pv", 32'(pix_valid), 32'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        frame_tick = 1'b1;
        step(2);
        frame_tick = 1'b0;
        check("rst_hold_done", 32'(done), 32'd0);
        check("rst_hold_frame", 32'(frame_sel), 32'd0);
        Reset_n = 1'b1;
        step(1);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);
        step(3);
        check("post_rst_hidden", 32'(pix_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
